lcd_8080_writer: RTL and testbench

- Output stage between the LCD DMA word stream and the external 8080-style parallel LCD bus (cs_n, d_c_n, wr_n, 16-bit databus).
- Buffers command and data words in a small FIFO.
- Generates write strobes with parameterised setup, low and high times.
- Holds chip-select low across back-to-back words and releases it after a programmable idle hold.

---
 rtl/lcd_8080_writer.sv | 219 +++++++++++++++++++++
 tb/tb_lcd_8080_writer.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_8080_writer.sv
`default_nettype none
// ============================================================================
// Module      : lcd_8080_writer
// Description : Output stage between the LCD DMA word stream and an
//               8080-style parallel LCD bus. Command/data words are buffered
//               in a small FIFO and written out with parameterised setup,
//               strobe-low and strobe-high times. Chip select stays low
//               across back-to-back words and is released after an idle hold.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   system clock
//   reset_n      in   asynchronous active-low reset
//   in_valid     in   upstream word valid
//   in_ready     out  FIFO can accept a word (level != FIFO_DEPTH)
//   in_data      in   16-bit pixel or command word
//   in_dc        in   1 = data word, 0 = command word
//   lcd_cs_n     out  LCD chip select, active low
//   lcd_d_c_n    out  data(1)/command(0) select
//   lcd_wr_n     out  write strobe, LCD latches on the rising edge
//   lcd_databus  out  16-bit LCD data bus
//   busy         out  FSM not idle, or FIFO not empty
//   fifo_level   out  current FIFO occupancy
// ============================================================================
module lcd_8080_writer #(
  parameter int FIFO_DEPTH  = 8,  // power of two, 2..64
  parameter int SETUP_CYC   = 1,  // bus valid to wr_n falling, >= 1
  parameter int WRL_CYC     = 2,  // wr_n low time, >= 1
  parameter int WRH_CYC     = 2,  // wr_n high time with bus held, >= 1
  parameter int CS_HOLD_CYC = 2   // idle clocks before cs_n rises, >= 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [15:0]                   in_data,
  input  logic                          in_dc,
  output logic                          lcd_cs_n,
  output logic                          lcd_d_c_n,
  output logic                          lcd_wr_n,
  output logic [15:0]                   lcd_databus,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int c_AW = $clog2(FIFO_DEPTH);
  localparam int c_LW = c_AW + 1;
  localparam int c_CW = 16;

  localparam logic [c_LW-1:0] c_FULL_LEVEL = c_LW'(FIFO_DEPTH);

  // Counters are loaded with (cycles - 1) and the phase ends when they hit 0.
  localparam logic [c_CW-1:0] c_SETUP_LD = c_CW'(SETUP_CYC - 1);
  localparam logic [c_CW-1:0] c_WRL_LD   = c_CW'(WRL_CYC - 1);
  localparam logic [c_CW-1:0] c_WRH_LD   = c_CW'(WRH_CYC - 1);
  localparam logic [c_CW-1:0] c_CSH_LD   = c_CW'(CS_HOLD_CYC - 1);

  localparam logic [2:0] c_ST_IDLE    = 3'd0;
  localparam logic [2:0] c_ST_SETUP   = 3'd1;
  localparam logic [2:0] c_ST_WR_LOW  = 3'd2;
  localparam logic [2:0] c_ST_WR_HIGH = 3'd3;
  localparam logic [2:0] c_ST_CS_HOLD = 3'd4;

  // --------------------------------------------------------------------------
  // FIFO storage: bit 16 carries the data/command flag alongside the word.
  // --------------------------------------------------------------------------
  logic [16:0]      r_mem [FIFO_DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_LW-1:0]  r_level;

  logic             w_push;
  logic             w_pop;
  logic             w_fifo_ne;
  logic [16:0]      w_head;

  // --------------------------------------------------------------------------
  // FSM and LCD output registers
  // --------------------------------------------------------------------------
  logic [2:0]       r_state;
  logic [c_CW-1:0]  r_cnt;
  logic             w_cnt_done;

  logic             r_cs_n;
  logic             r_d_c_n;
  logic             r_wr_n;
  logic [15:0]      r_bus;

  // Ready is derived from the registered level only, so a full FIFO refuses
  // a word even in a cycle where it is also being popped.
  assign in_ready   = (r_level != c_FULL_LEVEL);
  assign w_push     = in_valid && in_ready;
  assign w_fifo_ne  = (r_level != '0);
  assign w_head     = r_mem[r_rd_ptr];
  assign w_cnt_done = (r_cnt == '0);

  // Pops happen only at the points where a new word may be put on the bus:
  // from idle, at the end of the strobe-high phase, or at any cycle of the
  // chip-select hold (which keeps cs_n low across the gap).
  always_comb begin
    w_pop = 1'b0;
    case (r_state)
      c_ST_IDLE:    w_pop = w_fifo_ne;
      c_ST_WR_HIGH: w_pop = w_fifo_ne && w_cnt_done;
      c_ST_CS_HOLD: w_pop = w_fifo_ne;
      default:      w_pop = 1'b0;
    endcase
  end

  // Storage array is not reset: clearing the level/pointers discards
  // whatever it holds.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {in_dc, in_data};
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + c_LW'(1);
        2'b01:   r_level <= r_level - c_LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Write-cycle sequencer. A pop always starts a new word: the bus, d_c_n and
  // cs_n are registered on the pop edge and the setup counter is loaded, so
  // the bus never changes while wr_n is low.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_ST_IDLE;
      r_cnt   <= '0;
      r_cs_n  <= 1'b1;
      r_d_c_n <= 1'b1;
      r_wr_n  <= 1'b1;
      r_bus   <= '0;
    end else if (w_pop) begin
      r_state <= c_ST_SETUP;
      r_cnt   <= c_SETUP_LD;
      r_cs_n  <= 1'b0;
      r_wr_n  <= 1'b1;
      r_d_c_n <= w_head[16];
      r_bus   <= w_head[15:0];
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          r_cnt <= '0;
        end
        c_ST_SETUP: begin
          if (w_cnt_done) begin
            r_wr_n  <= 1'b0;
            r_state <= c_ST_WR_LOW;
            r_cnt   <= c_WRL_LD;
          end else begin
            r_cnt <= r_cnt - c_CW'(1);
          end
        end
        c_ST_WR_LOW: begin
          if (w_cnt_done) begin
            r_wr_n  <= 1'b1;
            r_state <= c_ST_WR_HIGH;
            r_cnt   <= c_WRH_LD;
          end else begin
            r_cnt <= r_cnt - c_CW'(1);
          end
        end
        c_ST_WR_HIGH: begin
          // A waiting word at the end of this phase is taken by the pop
          // branch above; reaching here at the end means the FIFO is empty.
          if (w_cnt_done) begin
            r_state <= c_ST_CS_HOLD;
            r_cnt   <= c_CSH_LD;
          end else begin
            r_cnt <= r_cnt - c_CW'(1);
          end
        end
        c_ST_CS_HOLD: begin
          // Bus and d_c_n keep their last values after cs_n is released.
          if (w_cnt_done) begin
            r_cs_n  <= 1'b1;
            r_state <= c_ST_IDLE;
          end else begin
            r_cnt <= r_cnt - c_CW'(1);
          end
        end
        default: begin
          r_state <= c_ST_IDLE;
          r_cnt   <= '0;
          r_cs_n  <= 1'b1;
          r_wr_n  <= 1'b1;
        end
      endcase
    end
  end

  assign lcd_cs_n    = r_cs_n;
  assign lcd_d_c_n   = r_d_c_n;
  assign lcd_wr_n    = r_wr_n;
  assign lcd_databus = r_bus;
  assign fifo_level  = r_level;
  assign busy        = (r_state != c_ST_IDLE) || w_fifo_ne;

endmodule
`default_nettype wire

// File: tb/tb_lcd_8080_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_8080_writer
// Description : Self-checking bench for lcd_8080_writer. Two instances run
//               side by side: default timing and a SETUP=3/WRL=1/WRH=4/HOLD=1
//               variant. A time-arithmetic reference model predicts the bus
//               control signals every cycle; accepted words go into a
//               per-instance scoreboard queue that the monitor drains on each
//               wr_n rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_8080_writer;

  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  function automatic int p_s(int k);  return (k == 0) ? 1 : 3; endfunction
  function automatic int p_wl(int k); return (k == 0) ? 2 : 1; endfunction
  function automatic int p_wh(int k); return (k == 0) ? 2 : 4; endfunction
  function automatic int p_ch(int k); return (k == 0) ? 2 : 1; endfunction
  function automatic int period(int k); return p_s(k) + p_wl(k) + p_wh(k); endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          vld [2];
  logic [15:0]   dat [2];
  logic          dci [2];
  logic          rdy [2];
  logic          cs  [2];
  logic          dcn [2];
  logic          wr  [2];
  logic          bsy [2];
  logic [15:0]   bus [2];
  logic [LW-1:0] lvl [2];

  lcd_8080_writer #(
    .FIFO_DEPTH(DEPTH), .SETUP_CYC(1), .WRL_CYC(2), .WRH_CYC(2), .CS_HOLD_CYC(2)
  ) u_dut0 (
    .clk(clk), .reset_n(rst_n), .in_valid(vld[0]), .in_ready(rdy[0]),
    .in_data(dat[0]), .in_dc(dci[0]), .lcd_cs_n(cs[0]), .lcd_d_c_n(dcn[0]),
    .lcd_wr_n(wr[0]), .lcd_databus(bus[0]), .busy(bsy[0]), .fifo_level(lvl[0])
  );

  lcd_8080_writer #(
    .FIFO_DEPTH(DEPTH), .SETUP_CYC(3), .WRL_CYC(1), .WRH_CYC(4), .CS_HOLD_CYC(1)
  ) u_dut1 (
    .clk(clk), .reset_n(rst_n), .in_valid(vld[1]), .in_ready(rdy[1]),
    .in_data(dat[1]), .in_dc(dci[1]), .lcd_cs_n(cs[1]), .lcd_d_c_n(dcn[1]),
    .lcd_wr_n(wr[1]), .lcd_databus(bus[1]), .busy(bsy[1]), .fifo_level(lvl[1])
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(string name, int k, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d @t=%0t: got 0x%0h required 0x%0h", name, k, $time, act, exp);
    end
  endtask

  task automatic fail_now(string name, int k);
    n_cmp++;
    n_bad++;
    $display("FAIL %s dut%0d @t=%0t", name, k, $time);
  endtask

  // --------------------------------------------------------------------------
  // Reference model: edge index t, per-instance occupancy, time of the last
  // pop and the edge at which that word's strobe-high phase ends.
  // --------------------------------------------------------------------------
  longint      t;
  int          m_level  [2];
  bit          m_active [2];
  longint      m_pop    [2];
  longint      m_end    [2];
  longint      m_push_t [2];
  bit          m_acc    [2];
  logic [16:0] sbq      [2][$];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_level[k]  = 0;
      m_active[k] = 1'b0;
      m_pop[k]    = -1000;
      m_end[k]    = -1000;
      m_acc[k]    = 1'b0;
      sbq[k].delete();
    end
  endtask

  task automatic model_step(int k);
    bit push;
    bit pop;
    push = vld[k] && (m_level[k] != DEPTH);
    pop  = 1'b0;
    if (m_level[k] > 0) begin
      if (!m_active[k]) pop = 1'b1;
      else if (t >= m_end[k] && t <= m_end[k] + p_ch(k)) pop = 1'b1;
    end
    if (pop) begin
      m_active[k] = 1'b1;
      m_pop[k]    = t;
      m_end[k]    = t + period(k);
    end else if (m_active[k] && t == m_end[k] + p_ch(k)) begin
      m_active[k] = 1'b0;
    end
    m_level[k] = m_level[k] + int'(push) - int'(pop);
    m_acc[k]   = push;
    if (push) begin
      sbq[k].push_back({dci[k], dat[k]});
      m_push_t[k] = t;
    end
  endtask

  initial begin
    t = 0;
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else begin
        t++;
        for (int k = 0; k < 2; k++) model_step(k);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  bit     prev_wr   [2];
  bit     prev_cs   [2];
  longint last_fall [2];
  longint last_rise [2];
  longint last_csr  [2];
  int     n_csr     [2];
  int     max_lvl   [2];
  longint rt        [2][$];

  task automatic mon_step(int k);
    bit          e_low;
    logic [16:0] w;
    e_low = m_active[k] && (t >= m_pop[k] + p_s(k)) && (t < m_pop[k] + p_s(k) + p_wl(k));
    check("ctrl{cs,wr,busy,rdy,lvl}", k,
          64'({cs[k], wr[k], bsy[k], rdy[k], lvl[k]}),
          64'({~m_active[k], ~e_low, (m_active[k] || m_level[k] != 0),
               (m_level[k] != DEPTH), LW'(m_level[k])}));
    if (int'(lvl[k]) > max_lvl[k]) max_lvl[k] = int'(lvl[k]);
    if (!prev_wr[k] && wr[k]) begin
      last_rise[k] = t;
      rt[k].push_back(t);
      if (sbq[k].size() == 0) fail_now("unexpected_write", k);
      else begin
        w = sbq[k].pop_front();
        check("word{dc,bus}", k, 64'({dcn[k], bus[k]}), 64'(w));
      end
    end
    if (prev_wr[k] && !wr[k]) last_fall[k] = t;
    if (!prev_cs[k] && cs[k]) begin
      last_csr[k] = t;
      n_csr[k]++;
    end
    prev_wr[k] = wr[k];
    prev_cs[k] = cs[k];
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      prev_wr[k] = 1'b1; prev_cs[k] = 1'b1; n_csr[k] = 0; max_lvl[k] = 0;
      last_fall[k] = 0; last_rise[k] = 0; last_csr[k] = 0;
    end
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int k = 0; k < 2; k++) begin prev_wr[k] = 1'b1; prev_cs[k] = 1'b1; end
      end else begin
        for (int k = 0; k < 2; k++) mon_step(k);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers (called at a negedge, return at a negedge)
  // --------------------------------------------------------------------------
  task automatic reset_check();
    for (int k = 0; k < 2; k++)
      check("reset{cs,wr,dc,bus,lvl,rdy,busy}", k,
            64'({cs[k], wr[k], dcn[k], bus[k], lvl[k], rdy[k], bsy[k]}),
            64'({1'b1, 1'b1, 1'b1, 16'h0000, LW'(0), 1'b1, 1'b0}));
  endtask

  task automatic send(int k, logic [15:0] d, logic c);
    int guard;
    guard  = 0;
    vld[k] = 1'b1;
    dat[k] = d;
    dci[k] = c;
    do begin
      @(posedge clk);
      #1;
      guard++;
    end while (!m_acc[k] && guard < 500);
    if (!m_acc[k]) fail_now("send_timeout", k);
    @(negedge clk);
  endtask

  task automatic burst(int k);
    send(k, 16'h002C, 1'b0);
    send(k, 16'hF800, 1'b1);
    send(k, 16'h07E0, 1'b1);
    send(k, 16'h001F, 1'b1);
    vld[k] = 1'b0;
  endtask

  task automatic stream(int k, int n);
    for (int i = 0; i < n; i++) send(k, 16'($urandom), 1'($urandom_range(0, 1)));
    vld[k] = 1'b0;
  endtask

  task automatic push_at(int k, longint target, logic [15:0] d, logic c);
    int guard;
    guard = 0;
    while (t < target - 1 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (t != target - 1) fail_now("push_at_missed", k);
    vld[k] = 1'b1; dat[k] = d; dci[k] = c;
    @(negedge clk);
    vld[k] = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (guard < 500 && (m_active[0] || m_active[1] || m_level[0] != 0 || m_level[1] != 0)) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) fail_now("idle_timeout", 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset(bool_mid_low);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #1 reset_check();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int     base_csr [2];
  longint p_t;
  longint tgt;
  int     guard;

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin vld[k] = 1'b0; dat[k] = '0; dci[k] = 1'b0; end
    repeat (3) @(posedge clk);
    #1 reset_check();
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    repeat (2) @(negedge clk);

    // Single command word on both instances
    fork
      send(0, 16'h002C, 1'b0);
      send(1, 16'h002C, 1'b0);
    join
    vld[0] = 1'b0; vld[1] = 1'b0;
    wait_idle();
    for (int k = 0; k < 2; k++) begin
      p_t = m_push_t[k];
      check("single_wr_fall_edge", k, 64'(last_fall[k]), 64'(p_t + 1 + p_s(k)));
      check("single_wr_rise_edge", k, 64'(last_rise[k]), 64'(p_t + 1 + p_s(k) + p_wl(k)));
      check("single_cs_rise_edge", k, 64'(last_csr[k]), 64'(p_t + 1 + period(k) + p_ch(k)));
    end

    // Four-word burst with in_valid held
    for (int k = 0; k < 2; k++) begin rt[k].delete(); base_csr[k] = n_csr[k]; end
    fork
      burst(0);
      burst(1);
    join
    wait_idle();
    for (int k = 0; k < 2; k++) begin
      check("burst_rise_count", k, 64'(rt[k].size()), 64'(4));
      for (int i = 1; i < rt[k].size(); i++)
        check("burst_period", k, 64'(rt[k][i] - rt[k][i-1]), 64'(period(k)));
      check("burst_cs_releases", k, 64'(n_csr[k] - base_csr[k]), 64'(1));
      check("burst_cs_after_last_rise", k, 64'(last_csr[k] - last_rise[k]), 64'(p_wh(k) + p_ch(k)));
    end

    // Continuous 12-word stream overfills the 8-entry FIFO
    for (int k = 0; k < 2; k++) begin rt[k].delete(); max_lvl[k] = 0; end
    fork
      stream(0, 12);
      stream(1, 12);
    join
    wait_idle();
    for (int k = 0; k < 2; k++) begin
      check("full_rise_count", k, 64'(rt[k].size()), 64'(12));
      check("full_peak_level", k, 64'(max_lvl[k]), 64'(DEPTH));
    end

    // Second word lands one clock into the chip-select hold
    base_csr[0] = n_csr[0];
    send(0, 16'hA5A5, 1'b1);
    vld[0] = 1'b0;
    tgt = m_push_t[0] + 1 + period(0) + 1;
    push_at(0, tgt, 16'h5A5A, 1'b0);
    wait_idle();
    check("reentry_cs_releases", 0, 64'(n_csr[0] - base_csr[0]), 64'(1));
    check("reentry_wr_fall_edge", 0, 64'(last_fall[0]), 64'(tgt + 1 + p_s(0)));

    // Random traffic with resets, including one landing in WR_LOW
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        vld[k] = ($urandom_range(0, 2) == 0);
        dat[k] = 16'($urandom);
        dci[k] = 1'($urandom_range(0, 1));
      end
      if (c == 120 || c == 260) begin
        guard = 0;
        while (wr[0] !== 1'b0 && guard < 80) begin
          @(negedge clk);
          guard++;
        end
        if (wr[0] !== 1'b0) fail_now("no_wr_low_to_interrupt", 0);
        #2 reset_pulse();
      end
      if (c == 330) begin
        @(posedge clk);
        #3 reset_pulse();
      end
    end
    vld[0] = 1'b0; vld[1] = 1'b0;
    wait_idle();
    for (int k = 0; k < 2; k++)
      check("scoreboard_drained", k, 64'(sbq[k].size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
